cmd_parser: RTL
===============

# cmd_parser

Front-end stage for the stream calculator. It accepts an ASCII character stream over a valid/ready byte handshake and parses decimal numbers and operator characters. It drives the calculator's `apply`/`op`/`in` command inputs with single-cycle command pulses. It also reports malformed input, so the calculator only ever sees well-formed 8-bit operands and legal opcodes.

## Interface
- No parameters.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rx_data` input 8: ASCII character.
- `rx_valid` input 1: `rx_data` is valid this cycle.
- `rx_ready` output 1: parser can accept a character this cycle.
- `apply` output 1: one-cycle command strobe to the calculator.
- `op` output 3: opcode. 0 add, 1 sub, 2 mul, 3 integer div, 4 fractional div, 5 push, 6 pop.
- `in` output 8: operand for push. Driven 0 for all other opcodes.
- `err` output 1: one-cycle error strobe.
- `err_code` output 2: 1 = illegal character, 2 = number exceeds 255. Valid only while `err`=1, 0 otherwise.

## Operation
- **Character classes:**
  - Digit `'0'`–`'9'`.
  - Delimiter: space (0x20), LF (0x0A), CR (0x0D).
  - Operator: `'+'`→0, `'-'`→1, `'*'`→2, `'/'`→3, `'f'`→4, `'p'`→6.
  - Anything else is illegal.
- **Accumulator:** `acc` is 12 bits wide. On each digit, `acc_next = acc*10 + (rx_data-0x30)`. Leading zeros are legal.
- **States:**
  - **IDLE** (no pending digits):
    - digit → `acc`=digit, go to NUM.
    - delimiter → ignored.
    - operator → emit op, stay in IDLE.
    - illegal → `err`, code 1, stay in IDLE.
  - **NUM** (pending number):
    - digit → if `acc_next` > 255: `err`, code 2, clear `acc`, go to SKIP. Otherwise update `acc`.
    - delimiter → emit push(`acc`), go to IDLE.
    - operator → emit push(`acc`), latch opcode, go to OPQ.
    - illegal → `err`, code 1, discard `acc`, go to SKIP.
  - **OPQ** (second half of number+operator):
    - `rx_ready`=0.
    - Emit the latched op next cycle, return to IDLE.
  - **SKIP** (discarding a bad token):
    - digits and illegal characters are silently dropped, with no further `err`.
    - delimiter → IDLE.
    - operator → emit op, go to IDLE.
- **Emit** means: `apply`=1 for exactly one cycle, with `op`/`in` valid in that same cycle.
- **Outputs between emits:** `apply`=0 and `op`=0. `op`/`in` may hold their last values in the cycle after an emit and must return to 0 after that.
- The calculator has no back-pressure, so every emit is unconditional.

## Timing
- **Acceptance:** a character is accepted on a rising edge where `rx_valid`=1 and `rx_ready`=1.
- **`rx_ready`:** 1 in IDLE, NUM and SKIP. 0 only in OPQ.
- **Latency:** `apply`/`err` are registered. They are asserted in the cycle immediately after the accepting edge (1-cycle latency).
- **Number followed by operator:** push strobe in cycle N+1, operator strobe in cycle N+2. No character is accepted at edge N+1.
- **Streaming:** back-to-back characters at one per cycle are sustained, except for the single OPQ bubble.
- **Error strobes:** `err` and `apply` are never both 1 in the same cycle.
- **Reset values:** `rx_ready`=1, `apply`=0, `op`=0, `in`=0, `err`=0, `err_code`=0, state=IDLE, `acc`=0.
- **Reset mid-operation:** reset in OPQ drops the latched operator. Reset in NUM discards the pending number.
- No partial command is ever emitted after reset is released.

## Test plan
- **Operand and add:** send `"20 20+"` one character per cycle. Required: push in=20, push in=20, then in the cycle after the push for the second number, `op`=0 with `apply`=1. Total of 3 apply pulses.
- **Overflow:** send `"255 256 "`. Required: push in=255; then `err`=1, `err_code`=2 on the `'6'` of 256; no further push; `"0"` in `" 0"` then pushes in=0 as a normal operand.
- **Illegal character:** send `"1x2 "`, then `"p"`. Required: `err`=1, `err_code`=1 once, with no push for `"1x2"`; then `apply`=1 with `op`=6 for `'p'`.
- **Operator-only and backpressure:** send `"7/f"` with `rx_valid` held high. Required:
  - `rx_ready`=0 for exactly one cycle after `'/'`.
  - `apply` sequence is push 7, op 3, op 4, on three consecutive-or-gapless emits.
  - No character is lost.
- **Reset mid-OPQ:** send `"9*"`, then assert `rst` during the OPQ cycle. Required: push 9 may appear, op 2 never appears, all outputs are at reset values, and `rx_ready`=1 after release.
- **Delimiters:** send `" \r\n 3\n"`. Required: exactly one apply, push in=3, and no `err`.

Source files
------------

// File: rtl/cmd_parser.sv
// cmd_parser: ASCII front end for the stream calculator.
// Parses decimal operands (0..255) and operator characters from a byte
// stream and turns them into single-cycle command strobes for the
// calculator. Malformed tokens raise a one-cycle error strobe instead.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   rx_data   ASCII character
//   rx_valid  rx_data valid this cycle
//   rx_ready  parser accepts a character this cycle (low only in OPQ)
//   apply     one-cycle command strobe
//   op        opcode: 0 add, 1 sub, 2 mul, 3 div, 4 fdiv, 5 push, 6 pop
//   in        push operand (0 for every other opcode)
//   err       one-cycle error strobe
//   err_code  1 = illegal character, 2 = number exceeds 255
module cmd_parser (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic       apply,
  output logic [2:0] op,
  output logic [7:0] in,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NUM  = 2'd1,
    S_OPQ  = 2'd2,
    S_SKIP = 2'd3
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'd5;

  state_t      state_r, state_s;
  logic [11:0] acc_r, acc_s;
  logic [2:0]  opq_r, opq_s;
  logic        rx_ready_r, rx_ready_s;
  logic        apply_r, apply_s;
  logic [2:0]  op_r, op_s;
  logic [7:0]  in_r, in_s;
  logic        err_r, err_s;
  logic [1:0]  err_code_r, err_code_s;

  logic        accept_s;
  logic        is_digit_s;
  logic        is_delim_s;
  logic        is_oper_s;
  logic [2:0]  oper_s;
  logic [3:0]  digit_s;
  logic [11:0] acc_next_s;

  assign rx_ready = rx_ready_r;
  assign apply    = apply_r;
  assign op       = op_r;
  assign in       = in_r;
  assign err      = err_r;
  assign err_code = err_code_r;

  assign accept_s = rx_valid & rx_ready_r;

  // Character classification and decimal accumulate step.
  always_comb begin
    is_delim_s = 1'b0;
    is_oper_s  = 1'b0;
    oper_s     = 3'd0;
    digit_s    = rx_data[3:0];
    if ((rx_data >= 8'h30) && (rx_data <= 8'h39)) begin
      is_digit_s = 1'b1;
    end else begin
      is_digit_s = 1'b0;
    end
    case (rx_data)
      8'h20, 8'h0A, 8'h0D: is_delim_s = 1'b1;
      8'h2B: begin is_oper_s = 1'b1; oper_s = 3'd0; end
      8'h2D: begin is_oper_s = 1'b1; oper_s = 3'd1; end
      8'h2A: begin is_oper_s = 1'b1; oper_s = 3'd2; end
      8'h2F: begin is_oper_s = 1'b1; oper_s = 3'd3; end
      8'h66: begin is_oper_s = 1'b1; oper_s = 3'd4; end
      8'h70: begin is_oper_s = 1'b1; oper_s = 3'd6; end
      default: begin
        is_delim_s = 1'b0;
        is_oper_s  = 1'b0;
      end
    endcase
    // acc never exceeds 255 while held, so acc*10+9 always fits in 12 bits.
    acc_next_s = (acc_r * 12'd10) + {8'd0, digit_s};
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_s    = state_r;
    acc_s      = acc_r;
    opq_s      = opq_r;
    apply_s    = 1'b0;
    op_s       = 3'd0;
    in_s       = 8'd0;
    err_s      = 1'b0;
    err_code_s = 2'd0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          if (is_digit_s) begin
            acc_s   = {8'd0, digit_s};
            state_s = S_NUM;
          end else if (is_oper_s) begin
            apply_s = 1'b1;
            op_s    = oper_s;
          end else if (is_delim_s) begin
            state_s = S_IDLE;
          end else begin
            err_s      = 1'b1;
            err_code_s = 2'd1;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_NUM: begin
        if (accept_s) begin
          if (is_digit_s) begin
            if (acc_next_s > 12'd255) begin
              err_s      = 1'b1;
              err_code_s = 2'd2;
              acc_s      = 12'd0;
              state_s    = S_SKIP;
            end else begin
              acc_s = acc_next_s;
            end
          end else if (is_delim_s) begin
            apply_s = 1'b1;
            op_s    = OP_PUSH;
            in_s    = acc_r[7:0];
            acc_s   = 12'd0;
            state_s = S_IDLE;
          end else if (is_oper_s) begin
            // Push now; the operator follows one cycle later from OPQ.
            apply_s = 1'b1;
            op_s    = OP_PUSH;
            in_s    = acc_r[7:0];
            acc_s   = 12'd0;
            opq_s   = oper_s;
            state_s = S_OPQ;
          end else begin
            err_s      = 1'b1;
            err_code_s = 2'd1;
            acc_s      = 12'd0;
            state_s    = S_SKIP;
          end
        end else begin
          state_s = S_NUM;
        end
      end
      S_OPQ: begin
        apply_s = 1'b1;
        op_s    = opq_r;
        opq_s   = 3'd0;
        state_s = S_IDLE;
      end
      S_SKIP: begin
        if (accept_s) begin
          if (is_delim_s) begin
            state_s = S_IDLE;
          end else if (is_oper_s) begin
            apply_s = 1'b1;
            op_s    = oper_s;
            state_s = S_IDLE;
          end else begin
            state_s = S_SKIP;
          end
        end else begin
          state_s = S_SKIP;
        end
      end
      default: begin
        state_s = S_IDLE;
        acc_s   = 12'd0;
        opq_s   = 3'd0;
      end
    endcase
    // Ready is registered from the next state so it is glitch-free.
    rx_ready_s = (state_s != S_OPQ);
  end

  // State, accumulator and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= S_IDLE;
      acc_r      <= 12'd0;
      opq_r      <= 3'd0;
      rx_ready_r <= 1'b1;
      apply_r    <= 1'b0;
      op_r       <= 3'd0;
      in_r       <= 8'd0;
      err_r      <= 1'b0;
      err_code_r <= 2'd0;
    end else begin
      state_r    <= state_s;
      acc_r      <= acc_s;
      opq_r      <= opq_s;
      rx_ready_r <= rx_ready_s;
      apply_r    <= apply_s;
      op_r       <= op_s;
      in_r       <= in_s;
      err_r      <= err_s;
      err_code_r <= err_code_s;
    end
  end

endmodule
